// File: rtl/bcd_modn_counter_if.sv
// Control and count bus of one BCD modulo-N counter stage.
// The master drives the controls and load value; the slave returns the count, carry/borrow and the load-reject pulse.
interface bcd_modn_counter_if #(
    parameter int DIGITS = 2
);
    logic                  en;
    logic                  up;
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   out;
    logic                  carryout;
    logic                  load_err;

    modport master (
        output en, up, clr, load, load_val,
        input  out, carryout, load_err
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output out, carryout, load_err
    );
endinterface

// File: rtl/bcd_modn_counter.sv
// Multi-digit packed-BCD up/down counter modulo MODULUS with clear, checked parallel load and same-cycle carry/borrow.
// Latency: count/clear/load visible one edge later; carryout is combinational. No backpressure: one step per enabled edge.
module bcd_modn_counter #(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60,
    parameter int INIT    = 0
) (
    input  logic               clk,
    input  logic               rst,
    bcd_modn_counter_if.slave  cnt
);
    localparam int W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int v);
        int r;
        r      = v;
        to_bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            to_bcd[4*i +: 4] = 4'(r % 10);
            r                = r / 10;
        end
    endfunction

    localparam logic [W-1:0] TERM     = to_bcd(MODULUS - 1);
    localparam logic [W-1:0] INIT_BCD = to_bcd(INIT);

    if (DIGITS < 1 || DIGITS > 4 || MODULUS < 2 || MODULUS > 10**DIGITS ||
        INIT < 0 || INIT >= MODULUS) begin : g_param_err
        $error("bcd_modn_counter: illegal DIGITS/MODULUS/INIT combination");
    end

    logic [W-1:0] cnt_q, cnt_d;
    logic         load_err_q, load_err_d;
    logic [W-1:0] inc_val, dec_val;
    logic         at_top, at_zero;
    logic         load_ok;

    assign at_top  = (cnt_q == TERM);
    assign at_zero = (cnt_q == '0);

    // Ripple through the digits: a 9 (up) or 0 (down) passes the carry onward.
    always_comb begin
        logic c_inc;
        logic c_dec;
        inc_val = cnt_q;
        dec_val = cnt_q;
        c_inc   = 1'b1;
        c_dec   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c_inc) begin
                if (cnt_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    c_inc             = 1'b0;
                end
            end
            if (c_dec) begin
                if (cnt_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                    c_dec             = 1'b0;
                end
            end
        end
    end

    // With every digit legal, packed-BCD order equals numeric order, so one compare against TERM bounds the value.
    always_comb begin
        load_ok = (cnt.load_val <= TERM);
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt.load_val[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        load_err_d = 1'b0;
        if (cnt.clr) begin
            cnt_d = '0;
        end else if (cnt.load) begin
            if (load_ok) begin
                cnt_d = cnt.load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (cnt.en) begin
            if (cnt.up) begin
                cnt_d = at_top ? '0 : inc_val;
            end else begin
                cnt_d = at_zero ? TERM : dec_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= INIT_BCD;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            load_err_q <= load_err_d;
        end
    end

    assign cnt.out      = cnt_q;
    assign cnt.load_err = load_err_q;
    assign cnt.carryout = cnt.en & ~cnt.clr & ~cnt.load & (cnt.up ? at_top : at_zero);
endmodule

// File: tb/tb_bcd_modn_counter.sv
// Bench for bcd_modn_counter: a mod-60 stage driven from a vector table and a mod-24 stage that can be cascaded off it.
module tb_bcd_modn_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic casc = 1'b0;
    logic en24 = 1'b0;

    always #5 clk = ~clk;

    bcd_modn_counter_if #(.DIGITS(2)) if60 ();
    bcd_modn_counter_if #(.DIGITS(2)) if24 ();

    assign if24.en = casc ? if60.carryout : en24;

    bcd_modn_counter #(.DIGITS(2), .MODULUS(60), .INIT(0)) u_sec (
        .clk (clk),
        .rst (rst),
        .cnt (if60)
    );

    bcd_modn_counter #(.DIGITS(2), .MODULUS(24), .INIT(0)) u_hr (
        .clk (clk),
        .rst (rst),
        .cnt (if24)
    );

    typedef struct {
        logic        clr, load, en, up;
        logic [7:0]  lv;
        logic        co;
        logic [7:0]  out;
        logic        err;
        string       nm;
    } vec_t;

    typedef struct packed {
        logic [7:0] out;
        logic       err;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    function automatic logic [7:0] bcd2(input int v);
        bcd2 = {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic add(input logic c, l, e, u, input logic [7:0] lv,
                       input logic co, input logic [7:0] o, input logic er, input string nm);
        vt.push_back('{c, l, e, u, lv, co, o, er, nm});
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input vec_t v);
        exp_t x;
        if60.clr = v.clr; if60.load = v.load; if60.en = v.en; if60.up = v.up; if60.load_val = v.lv;
        #1;
        chk({v.nm, "/carryout"}, 32'(if60.carryout), 32'(v.co));
        sb.push_back('{v.out, v.err});
        @(posedge clk); #1;
        x = sb.pop_front();
        chk({v.nm, "/out"}, 32'(if60.out), 32'(x.out));
        chk({v.nm, "/load_err"}, 32'(if60.load_err), 32'(x.err));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_co;
        vec_t h;
        exp_t x;

        if60.clr = 0; if60.load = 0; if60.en = 0; if60.up = 1; if60.load_val = 8'h00;
        if24.clr = 0; if24.load = 0; if24.up = 1; if24.load_val = 8'h00;
        #3;
        chk("reset/out", 32'(if60.out), 32'h00);
        chk("reset/load_err", 32'(if60.load_err), 32'h0);
        chk("reset/carryout", 32'(if60.carryout), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        //   clr  load en  up  load_val co   out    err
        add(0, 1, 1, 1, 8'h58, 0, 8'h58, 0, "ld58");
        add(0, 0, 1, 1, 8'h00, 0, 8'h59, 0, "inc58");
        add(0, 0, 1, 1, 8'h00, 1, 8'h00, 0, "wrap59");
        add(0, 1, 0, 1, 8'h09, 0, 8'h09, 0, "ld09");
        add(0, 0, 1, 1, 8'h00, 0, 8'h10, 0, "bcd_carry");
        add(0, 1, 0, 0, 8'h01, 0, 8'h01, 0, "ld01");
        add(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, "dec01");
        add(0, 0, 1, 0, 8'h00, 1, 8'h59, 0, "borrow00");
        add(0, 0, 1, 0, 8'h00, 0, 8'h58, 0, "dec59");
        add(0, 1, 0, 0, 8'h10, 0, 8'h10, 0, "ld10");
        add(0, 0, 1, 0, 8'h00, 0, 8'h09, 0, "bcd_borrow");
        add(0, 1, 0, 1, 8'h45, 0, 8'h45, 0, "ld45");
        add(0, 1, 1, 1, 8'h72, 0, 8'h45, 1, "rej72");
        add(0, 0, 0, 1, 8'h00, 0, 8'h45, 0, "err_pulse72");
        add(0, 1, 0, 1, 8'h3A, 0, 8'h45, 1, "rej3A");
        add(0, 0, 1, 1, 8'h00, 0, 8'h46, 0, "err_pulse3A");
        add(0, 1, 0, 1, 8'h59, 0, 8'h59, 0, "ld59");
        add(0, 0, 0, 1, 8'h00, 0, 8'h59, 0, "hold59");
        add(1, 1, 1, 1, 8'h12, 0, 8'h00, 0, "prio_clr");
        add(0, 1, 0, 1, 8'h59, 0, 8'h59, 0, "ld59b");
        add(0, 1, 1, 1, 8'h23, 0, 8'h23, 0, "prio_load");
        add(0, 1, 0, 1, 8'h72, 0, 8'h23, 1, "rej72b");
        add(1, 0, 0, 1, 8'h00, 0, 8'h00, 0, "clr_err");
        add(0, 1, 0, 1, 8'h30, 0, 8'h30, 0, "ld30");
        add(0, 0, 1, 1, 8'h00, 0, 8'h31, 0, "dir_up");
        add(0, 0, 1, 0, 8'h00, 0, 8'h30, 0, "dir_down");
        add(0, 0, 1, 0, 8'h00, 0, 8'h29, 0, "dir_down2");
        add(0, 1, 0, 1, 8'h60, 0, 8'h29, 1, "rej60");

        foreach (vt[i]) step(vt[i]);

        // en low: count holds regardless of direction or load_val wiggling
        for (int i = 0; i < 10; i++) begin
            h = '{0, 0, 0, i[0], 8'($urandom_range(0, 255)), 0, 8'h29, 0, "hold10"};
            step(h);
        end

        // Stand-alone mod-24 pass: exactly one carry, at 0x23
        en24 = 1'b1;
        n_co = 0;
        for (int i = 0; i < 24; i++) begin
            #1;
            if (if24.carryout) n_co++;
            chk("m24/carryout", 32'(if24.carryout), 32'(i == 23));
            @(posedge clk); #1;
            chk("m24/out", 32'(if24.out), 32'(bcd2((i + 1) % 24)));
            @(negedge clk);
        end
        chk("m24/carry_count", 32'(n_co), 32'd1);
        en24 = 1'b0;

        // Cascade: 23:58 -> 23:59 -> 00:00 with both stages wrapping on one edge
        if60.load = 1; if60.load_val = 8'h58; if60.en = 0; if60.up = 1;
        if24.load = 1; if24.load_val = 8'h23;
        @(posedge clk); #1;
        chk("casc/ld_sec", 32'(if60.out), 32'h58);
        chk("casc/ld_hr", 32'(if24.out), 32'h23);
        @(negedge clk);
        if60.load = 0; if24.load = 0; casc = 1'b1; if60.en = 1;
        #1;
        chk("casc/hr_co_58", 32'(if24.carryout), 32'h0);
        @(posedge clk); #1;
        chk("casc/sec59", 32'(if60.out), 32'h59);
        chk("casc/hr23", 32'(if24.out), 32'h23);
        @(negedge clk); #1;
        chk("casc/sec_co", 32'(if60.carryout), 32'h1);
        chk("casc/hr_co", 32'(if24.carryout), 32'h1);
        @(posedge clk); #1;
        chk("casc/sec_wrap", 32'(if60.out), 32'h00);
        chk("casc/hr_wrap", 32'(if24.out), 32'h00);
        @(negedge clk);
        casc = 1'b0; if60.en = 0;

        // Asynchronous reset mid-cycle with load_err pending
        h = '{0, 1, 0, 1, 8'h37, 0, 8'h37, 0, "ld37"};
        step(h);
        h = '{0, 1, 0, 1, 8'h99, 0, 8'h37, 1, "rej99"};
        step(h);
        if60.load = 0;
        #2 rst = 1'b0;
        #1;
        chk("arst/out", 32'(if60.out), 32'h00);
        chk("arst/load_err", 32'(if60.load_err), 32'h0);
        if60.en = 1; if60.up = 1;
        @(negedge clk);
        chk("arst/held_out", 32'(if60.out), 32'h00);
        rst = 1'b1;
        sb.push_back('{8'h01, 1'b0});
        @(posedge clk); #1;
        x = sb.pop_front();
        chk("arst/first_count", 32'(if60.out), 32'(x.out));
        chk("arst/first_err", 32'(if60.load_err), 32'(x.err));
        if60.en = 0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
